// File: rtl/packet_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : packet_serializer
//  Purpose  : Snapshots player position plus NUM_WAVES wave records on a
//             start request and streams the frame out one byte per transfer
//             over a valid/ready byte interface.
//             Frame: SYNC lo, SYNC hi, player_x, player_y, then per wave
//             wave_y followed by FIELD_W/8 bitfield bytes (LSB first).
//  Option   : `define PKT_CHECKSUM_EN appends one byte holding the XOR of all
//             bytes after the sync word.
//  Ports    : clk, rst_n (async, active-low)
//             start                    - frame request, sampled only in IDLE
//             player_x, player_y       - position bytes
//             wave_y                   - wave i Y at [8i+7:8i]
//             wave_bitfield            - wave i bitfield at [FIELD_W*i +: FIELD_W]
//             out_data/out_valid/out_ready - byte stream handshake
//             busy                     - frame held or in transmission
//             frame_done               - pulse on the last byte's transfer
//  Revision : 1.0 - initial release
// ============================================================================
module packet_serializer #(
  parameter int          NUM_WAVES = 3,
  parameter int          FIELD_W   = 40,
  parameter logic [15:0] SYNC_WORD = 16'h55AA
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   player_x,
  input  logic [7:0]                   player_y,
  input  logic [8*NUM_WAVES-1:0]       wave_y,
  input  logic [FIELD_W*NUM_WAVES-1:0] wave_bitfield,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int FIELD_BYTES = FIELD_W / 8;
  localparam int BASE_LEN    = 4 + NUM_WAVES * (1 + FIELD_BYTES);
  // Payload = everything after the two sync bytes; only this is snapshotted.
  localparam int PAYLOAD_LEN = BASE_LEN - 2;
`ifdef PKT_CHECKSUM_EN
  localparam int FRAME_LEN   = BASE_LEN + 1;
`else
  localparam int FRAME_LEN   = BASE_LEN;
`endif
  localparam int             CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [8*PAYLOAD_LEN-1:0] r_snap;
  logic [8*PAYLOAD_LEN-1:0] w_payload_in;
  logic [7:0]               w_next_byte;
  logic                     w_last;

  // --------------------------------------------------------------------------
  // Payload assembly from the live inputs (captured only on start in IDLE)
  // --------------------------------------------------------------------------
  assign w_payload_in[7:0]  = player_x;
  assign w_payload_in[15:8] = player_y;

  generate
    for (genvar i = 0; i < NUM_WAVES; i++) begin : g_wave
      localparam int BASE = 16 + i * 8 * (1 + FIELD_BYTES);
      assign w_payload_in[BASE +: 8]        = wave_y[8*i +: 8];
      assign w_payload_in[BASE + 8 +: FIELD_W] = wave_bitfield[FIELD_W*i +: FIELD_W];
    end
  endgenerate

`ifdef PKT_CHECKSUM_EN
  // Checksum is a pure function of the snapshot, so it is already settled
  // long before the counter reaches it; no extra pipeline bubble needed.
  logic [7:0] w_checksum;
  always_comb begin
    w_checksum = '0;
    for (int k = 0; k < PAYLOAD_LEN; k++) begin
      w_checksum = w_checksum ^ r_snap[8*k +: 8];
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Byte following the one currently presented (index r_cnt + 1).
  // out_data is registered, so the next byte is loaded on each transfer.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_byte = '0;
    if (r_cnt == '0) begin
      w_next_byte = SYNC_WORD[15:8];
    end
    for (int k = 0; k < PAYLOAD_LEN; k++) begin
      if (r_cnt == CNT_W'(k + 1)) begin
        w_next_byte = r_snap[8*k +: 8];
      end
    end
`ifdef PKT_CHECKSUM_EN
    if (r_cnt == CNT_W'(BASE_LEN - 1)) begin
      w_next_byte = w_checksum;
    end
`endif
  end

  assign w_last     = (r_cnt == LAST_IDX);
  // out_valid is high throughout SEND, so state + ready marks a transfer.
  assign frame_done = (r_state == S_SEND) && out_ready && w_last;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_snap    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap    <= w_payload_in;
            r_cnt     <= '0;
            out_data  <= SYNC_WORD[7:0];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          // Without ready everything holds: data and valid stay stable.
          if (out_ready) begin
            if (w_last) begin
              r_state   <= S_IDLE;
              r_cnt     <= '0;
              out_data  <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              r_cnt    <= r_cnt + 1'b1;
              out_data <= w_next_byte;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
